// File: rtl/bus_arbiter.sv
// bus_arbiter: 3-way round-robin bus arbiter with a 1-cycle turnaround gap; optional hold timeout (BUS_ARB_TIMEOUT_EN).
// Latency: grant 1 cycle after sampled req; release/revocation drops gnt 1 cycle after the edge, then 1 TURN cycle.
// Backpressure: requesters hold req level until granted; the owner keeps the bus until rel, req drop or timeout.
module bus_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] rel,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       bus_busy,
  output logic       timeout
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] TURN  = 2'b10;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("bus_arbiter: HOLD_MAX out of range 1..255");
  end

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] win;
  logic       own_rel;
  logic       own_req;

  // Priority after owner 'last' is last+1, last+2, then last itself (mod 3).
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = 2'd0;
    c2 = 2'd0;
    case (l)
      2'd0:    begin c1 = 2'd1; c2 = 2'd2; end
      2'd1:    begin c1 = 2'd2; c2 = 2'd0; end
      default: begin c1 = 2'd0; c2 = 2'd1; end
    endcase
    if (r[c1])      pick = c1;
    else if (r[c2]) pick = c2;
    else            pick = l;
  endfunction

  always_comb begin
    win     = pick(req, last);
    own_rel = |(rel & gnt);
    own_req = |(req & gnt);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0] hold_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      gnt_id   <= 2'b11;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      last     <= 2'd2;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= 3'b001 << win;
            gnt_id   <= win;
            bus_busy <= 1'b1;
            last     <= win;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // A release in the expiry cycle wins, so no timeout pulse then.
          if (own_rel || !own_req) begin
            state    <= TURN;
            gnt      <= 3'b000;
            gnt_id   <= 2'b11;
            bus_busy <= 1'b0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_LIM - 8'd1) begin
            state    <= TURN;
            gnt      <= 3'b000;
            gnt_id   <= 2'b11;
            bus_busy <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          gnt      <= 3'b000;
          gnt_id   <= 2'b11;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (HOLD_MAX=4); covers the timeout path when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] rel;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_busy;
  logic       timeout;
  logic       mon_en = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rel      (rel),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] id_of(input logic [2:0] g);
    case (g)
      3'b001:  id_of = 2'd0;
      3'b010:  id_of = 2'd1;
      3'b100:  id_of = 2'd2;
      default: id_of = 2'b11;
    endcase
  endfunction

  // Structural properties of the grant outputs, every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("id_map", 32'(gnt_id), 32'(id_of(gnt)));
      chk("busy_map", 32'(bus_busy), 32'(|gnt));
    end
  end

  initial begin
    rst = 1'b0;
    req = 3'b000;
    rel = 3'b000;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd3);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    mon_en = 1'b1;

    req = 3'b111;
    tick();
    chk("rst_ign_req", 32'(gnt), 32'd0);

    // Full contention: order 0,1,2,0 with one empty cycle between grants.
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_g1", 32'(gnt), 32'(3'b001 << (k % 3)));
      chk("rr_id", 32'(gnt_id), 32'(k % 3));
      tick();
      chk("rr_g2", 32'(gnt), 32'(3'b001 << (k % 3)));
      rel = 3'b001 << (k % 3);
      if (k == 3) req = 3'b000;
      tick();
      rel = 3'b000;
      chk("rr_gap", 32'(gnt), 32'd0);
      chk("rr_gap_to", 32'(timeout), 32'd0);
      tick();
    end
    chk("rr_idle", 32'(gnt), 32'd0);

    // Sole requester 1: held 3 cycles, gap, re-granted.
    req = 3'b010;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("solo_hold", 32'(gnt), 32'b010);
      if (c < 2) tick();
    end
    rel = 3'b010;
    tick();
    rel = 3'b000;
    chk("solo_gap", 32'(gnt), 32'd0);
    tick();
    chk("solo_regnt", 32'(gnt), 32'b010);
    chk("solo_id", 32'(gnt_id), 32'd1);

    // Owner 0; non-owner rel and req changes are ignored.
    rel = 3'b010;
    req = 3'b001;
    tick();
    rel = 3'b000;
    chk("to0_gap", 32'(gnt), 32'd0);
    tick();
    chk("own0", 32'(gnt), 32'b001);
    rel = 3'b100;
    req = 3'b111;
    tick();
    rel = 3'b000;
    chk("nonown_rel", 32'(gnt), 32'b001);
    chk("nonown_id", 32'(gnt_id), 32'd0);
    rel = 3'b010;
    req = 3'b001;
    tick();
    rel = 3'b000;
    chk("nonown_rel2", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    chk("req_drop", 32'(gnt), 32'd0);
    tick();
    chk("drop_idle", 32'(gnt), 32'd0);

    req = 3'b100;
    tick();
    chk("hold_g1", 32'(gnt), 32'b100);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("hold_gn", 32'(gnt), 32'b100);
      chk("hold_to0", 32'(timeout), 32'd0);
    end
    tick();
    chk("tmo_gnt", 32'(gnt), 32'd0);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    tick();
    chk("tmo_regnt", 32'(gnt), 32'b100);
    chk("tmo_clear", 32'(timeout), 32'd0);
    tick();
    tick();
    tick();
    chk("rel_at_exp_g4", 32'(gnt), 32'b100);
    rel = 3'b100;
    tick();
    rel = 3'b000;
    chk("rel_at_exp_gnt", 32'(gnt), 32'd0);
    chk("rel_at_exp_to", 32'(timeout), 32'd0);
    req = 3'b000;
    tick();
`else
    for (int c = 0; c < 120; c++) begin
      tick();
      chk("hold_forever", 32'(gnt), 32'b100);
      chk("hold_no_to", 32'(timeout), 32'd0);
    end
    rel = 3'b100;
    req = 3'b000;
    tick();
    rel = 3'b000;
    chk("hold_rel", 32'(gnt), 32'd0);
    tick();
`endif
    chk("pre_rst_idle", 32'(gnt), 32'd0);

    // Reset in owner 1's second grant cycle clears ownership and pointer.
    req = 3'b010;
    tick();
    chk("r_g1", 32'(gnt), 32'b010);
    tick();
    chk("r_g2", 32'(gnt), 32'b010);
    rst = 1'b0;
    tick();
    chk("r_gnt", 32'(gnt), 32'd0);
    chk("r_id", 32'(gnt_id), 32'd3);
    chk("r_busy", 32'(bus_busy), 32'd0);
    chk("r_to", 32'(timeout), 32'd0);
    tick();
    chk("r_hold", 32'(gnt), 32'd0);
    rst = 1'b1;
    req = 3'b111;
    tick();
    chk("r_first", 32'(gnt), 32'b001);
    chk("r_first_id", 32'(gnt_id), 32'd0);
    req = 3'b000;
    tick();
    chk("end_gap", 32'(gnt), 32'd0);
    tick();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, 8, maximum consecutive GRANT cycles per ownership; legal range 1..255; used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-low.
REQ-004 Port: req  input  3  bus request; bit i from requester i (0 = fetch, 1 = ALU sequencer, 2 = move sequencer); level, held until granted or abandoned.
REQ-005 Port: rel  input  3  release; bit i pulses one cycle while requester i owns the bus.
REQ-006 Port: gnt  output  3  registered grant; one-hot or all-zero.
REQ-007 Port: gnt_id  output  2  index of current owner; 2'b11 when no owner.
REQ-008 Port: bus_busy  output  1  high exactly when gnt is nonzero.
REQ-009 Port: timeout  output  1  one-cycle pulse on forced revocation.

Function
REQ-010 States: IDLE, GRANT, TURN; 2-bit registered state; all outputs are registered.
REQ-011 IDLE: req == 0 -> stay IDLE; otherwise select the winner per REQ-015, enter GRANT, and assert gnt[winner] after the same edge (latency 1 cycle from sampled req).
REQ-012 GRANT: owner keeps gnt while req[owner]=1 and rel[owner]=0.
REQ-013 GRANT exit: rel[owner]=1 or req[owner]=0 -> gnt=0 after next edge, enter TURN.
REQ-014 rel bits of non-owners and req changes of non-owners have no effect in GRANT.
REQ-015 Round-robin: pointer last holds the most recent owner; priority order is (last+1)%3, (last+2)%3, last.
REQ-016 last updates on every entry to GRANT.
REQ-017 TURN: lasts exactly one cycle with gnt=0, guaranteeing a one-cycle tri-state turnaround gap.
REQ-018 End of TURN: req != 0 -> arbitrate per REQ-015 and enter GRANT; else IDLE.
REQ-019 Minimum gap between two grants is exactly one idle cycle.
REQ-020 A sole requester re-requesting after release is re-granted after the TURN cycle.
REQ-021 gnt never has more than one bit set in any cycle.
REQ-022 gnt_id equals the index of the set gnt bit, else 2'b11.
REQ-023 Simultaneous rel[owner] and timeout expiry in the same cycle is treated as a normal release; timeout stays 0.

Reset
REQ-024 With rst=0 at a clock edge: state=IDLE, gnt=3'b000, gnt_id=2'b11, bus_busy=0, timeout=0, last=2 (requester 0 highest priority), hold counter=0.
REQ-025 Reset asserted during GRANT drops gnt at that edge, with no TURN cycle and no timeout pulse.
REQ-026 While rst=0, req and rel are ignored.

Configuration
REQ-027 Macro BUS_ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on GRANT entry and increments each GRANT cycle.
REQ-028 With the macro, on the HOLD_MAX-th consecutive GRANT cycle without release, the grant is revoked: gnt=0 after that edge, state enters TURN, and timeout=1 for that one cycle.
REQ-029 Macro undefined: no counter is present, timeout is tied 0, and a grant is held indefinitely until release per REQ-013.

Verification
REQ-030 Reset then req=3'b111 held, each owner pulses rel 2 cycles after grant -> grant order 0,1,2,0 with one zero-gnt cycle between grants.
REQ-031 req=3'b010 only, rel[1] after 3 cycles, req held -> gnt=3'b010 (3 cycles), gnt=3'b000 (1 cycle), gnt=3'b010 again.
REQ-032 Owner 0 in GRANT, rel=3'b100 pulsed (non-owner) -> gnt stays 3'b001, gnt_id stays 0.
REQ-033 BUS_ARB_TIMEOUT_EN, HOLD_MAX=4, req[2] held without rel -> gnt=3'b100 for 4 cycles, then gnt=0 with timeout=1 for one cycle, then regrant to 2.
REQ-034 Same as REQ-033 without the macro -> gnt=3'b100 held 100+ cycles, timeout constantly 0.
REQ-035 rst driven 0 in the 2nd GRANT cycle of owner 1 -> next edge gnt=0, gnt_id=2'b11; after release, req=3'b111 grants 0 first.
